// File: rtl/audio_pkg.sv
// Shared types and constants for the audio playback path.
// Fetch FSM states, widths and the default flash sample region.
package audio_pkg;

    localparam int FLASH_ADDR_W = 23;
    localparam int SAMPLE_W     = 16;
    localparam int WORD_W       = 32;

    localparam logic [FLASH_ADDR_W-1:0] DEF_START_ADDR = 23'h000000;
    localparam logic [FLASH_ADDR_W-1:0] DEF_LAST_ADDR  = 23'h07FFFF;

    typedef enum logic [1:0] {
        IDLE,
        READ_REQ,
        WAIT_DATA,
        EMIT
    } fetch_state_t;

    // Upper or lower sample of a flash word.
    function automatic logic [SAMPLE_W-1:0] pick_half(
        input logic [WORD_W-1:0] w,
        input logic              hi
    );
        return hi ? w[WORD_W-1:SAMPLE_W] : w[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/flash_addr_stepper.sv
// Flash word-address register for the sample region.
// Steps +/-1 with wrap inside the region; restart load has priority.
module flash_addr_stepper
    import audio_pkg::*;
#(
    parameter int                 ADDR_W     = FLASH_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = DEF_START_ADDR,
    parameter logic [ADDR_W-1:0] LAST_ADDR  = DEF_LAST_ADDR
) (
    input  logic              clock50,
    input  logic              rstn,
    input  logic              load,
    input  logic              load_fwd,
    input  logic              step,
    input  logic              step_fwd,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] addr_nx;

    // Neighbour address, wrapping at the region ends.
    always_comb begin
        addr_nx = addr;
        if (step_fwd) begin
            addr_nx = (addr == LAST_ADDR) ? START_ADDR
                                          : addr + ADDR_W'(1);
        end else begin
            addr_nx = (addr == START_ADDR) ? LAST_ADDR
                                           : addr - ADDR_W'(1);
        end
    end

    // Address register: restart load, else step.
    always_ff @(posedge clock50) begin
        if (!rstn) begin
            addr <= START_ADDR;
        end else if (load) begin
            addr <= load_fwd ? START_ADDR : LAST_ADDR;
        end else if (step) begin
            addr <= addr_nx;
        end
    end

endmodule

// File: rtl/flash_sample_fetch.sv
// Reads 32-bit flash words and plays them out as 16-bit samples.
// One sample per tick, forward/reverse, pause and restart.
module flash_sample_fetch
    import audio_pkg::*;
#(
    parameter int                 ADDR_W     = FLASH_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = DEF_START_ADDR,
    parameter logic [ADDR_W-1:0] LAST_ADDR  = DEF_LAST_ADDR
) (
    input  logic                clock50,
    input  logic                rstn,
    input  logic                sample_req,
    input  logic                play_en,
    input  logic                dir_fwd,
    input  logic                restart,
    output logic                flash_mem_read,
    output logic [ADDR_W-1:0]   flash_mem_address,
    output logic [3:0]          flash_mem_byteenable,
    input  logic                flash_mem_waitrequest,
    input  logic [WORD_W-1:0]   flash_mem_readdata,
    input  logic                flash_mem_readdatavalid,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                busy,
    output logic                overrun
);

    fetch_state_t state;
    fetch_state_t state_nx;

    logic [WORD_W-1:0] word_buf;
    logic              buf_valid;
    logic              half_ptr;
    logic              word_fwd;
    logic              pre_emit;
    logic              rst_pend;
    logic              rst_fwd;

    logic req_ok;
    logic in_flight;
    logic cap;
    logic discard;
    logic step;
    logic load;
    logic load_fwd;

    assign req_ok    = sample_req & play_en;
    assign in_flight = (state == READ_REQ) || (state == WAIT_DATA);

    assign busy                 = in_flight;
    assign flash_mem_read       = (state == READ_REQ);
    assign flash_mem_byteenable = 4'hF;

    flash_addr_stepper #(
        .ADDR_W    (ADDR_W),
        .START_ADDR(START_ADDR),
        .LAST_ADDR (LAST_ADDR)
    ) u_addr (
        .clock50 (clock50),
        .rstn    (rstn),
        .load    (load),
        .load_fwd(load_fwd),
        .step    (step),
        .step_fwd(word_fwd),
        .addr    (flash_mem_address)
    );

    // Next state plus capture/discard/address-step decisions.
    always_comb begin
        state_nx = state;
        cap      = 1'b0;
        discard  = 1'b0;
        step     = 1'b0;
        load     = 1'b0;
        load_fwd = dir_fwd;
        unique case (state)
            IDLE: begin
                if (restart) begin
                    load = 1'b1;
                end else if (req_ok) begin
                    state_nx = buf_valid ? EMIT : READ_REQ;
                end
            end
            READ_REQ: begin
                if (!flash_mem_waitrequest) begin
                    state_nx = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (flash_mem_readdatavalid) begin
                    if (rst_pend || restart) begin
                        discard  = 1'b1;
                        load     = 1'b1;
                        load_fwd = restart ? dir_fwd : rst_fwd;
                        state_nx = IDLE;
                    end else begin
                        cap      = 1'b1;
                        state_nx = EMIT;
                    end
                end
            end
            EMIT: begin
                state_nx = IDLE;
                if (restart) begin
                    load = 1'b1;
                end else if (half_ptr) begin
                    step = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock50) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Remember a restart seen mid-transaction and its direction.
    always_ff @(posedge clock50) begin
        if (!rstn) begin
            rst_pend <= 1'b0;
            rst_fwd  <= 1'b1;
        end else if (discard) begin
            rst_pend <= 1'b0;
        end else if (in_flight && restart) begin
            rst_pend <= 1'b1;
            rst_fwd  <= dir_fwd;
        end
    end

    // Word buffer, half pointer and sample outputs.
    // A fresh word's first half goes out straight from readdata.
    always_ff @(posedge clock50) begin
        if (!rstn) begin
            word_buf     <= '0;
            buf_valid    <= 1'b0;
            half_ptr     <= 1'b0;
            word_fwd     <= 1'b1;
            pre_emit     <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            overrun      <= req_ok && ((state != IDLE) || restart);
            if (cap) begin
                word_buf     <= flash_mem_readdata;
                buf_valid    <= 1'b1;
                half_ptr     <= 1'b0;
                word_fwd     <= dir_fwd;
                pre_emit     <= 1'b1;
                sample_out   <= pick_half(flash_mem_readdata, ~dir_fwd);
                sample_valid <= 1'b1;
            end
            if (state == EMIT) begin
                if (!pre_emit) begin
                    sample_out   <= pick_half(word_buf,
                                              word_fwd ? half_ptr : ~half_ptr);
                    sample_valid <= 1'b1;
                end
                pre_emit <= 1'b0;
                half_ptr <= ~half_ptr;
                if (half_ptr) begin
                    buf_valid <= 1'b0;
                end
            end
            if (load) begin
                buf_valid <= 1'b0;
                half_ptr  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/flash_sample_fetch.md
Name: flash_sample_fetch

Overview:
- Upstream stage of the audio playback path. On each sample-tick strobe it reads 32-bit words from the on-board flash over the Avalon-MM read interface.
- Splits each word into two 16-bit audio samples and presents one sample per tick on sample_out / sample_valid.
- sample_out feeds the getdata input of the downstream audio pass stage.
- Supports forward/reverse playback, pause, and restart, with address wrap-around.

Parameters:
- ADDR_W, 23, flash word-address width.
- START_ADDR, 23'h000000, first word address of the sample region.
- LAST_ADDR, 23'h07FFFF, last word address of the sample region (inclusive).

Ports:
- clock50  in  1  system clock, 50 MHz.
- rstn  in  1  synchronous active-low reset.
- sample_req  in  1  one-cycle strobe per audio sample, already synchronized into the clock50 domain.
- play_en  in  1  1 = play, 0 = pause (sample_req ignored).
- dir_fwd  in  1  1 = forward, 0 = reverse.
- restart  in  1  one-cycle strobe: jump to the start of the region for the current direction.
- flash_mem_read  out  1  Avalon read request.
- flash_mem_address  out  ADDR_W  Avalon word address.
- flash_mem_byteenable  out  4  constant 4'hF.
- flash_mem_waitrequest  in  1  Avalon stall.
- flash_mem_readdata  in  32  Avalon read data.
- flash_mem_readdatavalid  in  1  Avalon data strobe.
- sample_out  out  16  current sample; held between updates.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  a flash transaction is in flight.
- overrun  out  1  one-cycle pulse when a sample_req is dropped.

Behaviour:
- Reset is synchronous on rstn=0, with these values:
  - flash_mem_read=0, flash_mem_address=START_ADDR.
  - sample_out=16'h0, sample_valid=0, busy=0, overrun=0.
  - word buffer invalid, half pointer=0, state=IDLE.
- Reset asserted mid-transaction abandons the transaction immediately. Any late readdatavalid after reset is ignored because state is IDLE.
- State machine has four states: IDLE, READ_REQ, WAIT_DATA, EMIT.
  - IDLE:
    - sample_req=1, play_en=1, buffer holds an unused half: go to EMIT (no flash access).
    - Same conditions but no unused half: go to READ_REQ.
  - READ_REQ: flash_mem_read=1, address stable. Stay while flash_mem_waitrequest=1. On waitrequest=0 drop read and go to WAIT_DATA.
  - WAIT_DATA: on readdatavalid, capture the 32-bit word, latch the direction for that word, mark the buffer valid, go to EMIT.
  - EMIT:
    - Load sample_out with the selected half and pulse sample_valid for 1 cycle.
    - Advance the half pointer. When the second half is consumed, mark the buffer invalid and step the address.
    - Return to IDLE.
- Half order is fixed by the direction latched at word capture:
  - forward: [15:0] first, then [31:16].
  - reverse: [31:16] first, then [15:0].
- Address stepping:
  - forward: +1, with LAST_ADDR wrapping to START_ADDR.
  - reverse: −1, with START_ADDR wrapping to LAST_ADDR.
  - No arithmetic overflow beyond the region is permitted.
- A dir_fwd change takes effect at the next word fetch. The current buffered half is still emitted.
- Latency:
  - Buffered half: sample_valid 2 cycles after the sample_req cycle.
  - Fetch: sample_valid 1 cycle after the readdatavalid cycle.
- busy=1 in READ_REQ and WAIT_DATA.
- A sample_req arriving in any state other than IDLE, with play_en=1, is dropped and overrun pulses 1 cycle. A sample_req with play_en=0 is ignored, no overrun.
- restart:
  - In IDLE: address := START_ADDR if dir_fwd, else LAST_ADDR; buffer invalidated.
  - During READ_REQ/WAIT_DATA: restart is recorded. The Avalon transaction completes, the data is discarded (no sample_valid), the address is reloaded, and the FSM returns to IDLE.
  - Simultaneous with sample_req in IDLE: restart wins and the request counts as a drop (overrun pulse).
- Pause (play_en=0) never aborts an in-flight transaction. The word is captured and emitted normally.

Decomposition:
- Shared package audio_pkg holds:
  - the fetch state enum typedef;
  - localparams FLASH_ADDR_W=23, SAMPLE_W=16, WORD_W=32;
  - the default START/LAST addresses.
- One natural sub-module: flash_addr_stepper (address register with ±1 step, wrap and restart load). The FSM stays in this module.

Test Plan:
1. Forward, word 0 = 32'hBEEF_1234, waitrequest low: sample_req → sample_out=16'h1234 valid; next req → 16'hBEEF with no flash_mem_read; third req → read at address 1.
2. Reverse from restart, word at LAST_ADDR = 32'hAAAA_5555: first req reads address 23'h07FFFF → 16'hAAAA, then 16'h5555; next fetch address 23'h07FFFE.
3. Wrap: forward at LAST_ADDR, consume both halves → next read address 0. Reverse at address 0 → next read 23'h07FFFF.
4. waitrequest held 5 cycles, readdatavalid 3 cycles later, sample_req issued during WAIT_DATA: read held 6 cycles; overrun pulses once; exactly one sample_valid.
5. restart during WAIT_DATA: no sample_valid for that word; next read address = START_ADDR (fwd).
6. rstn=0 during READ_REQ, then readdatavalid pulse after release: outputs at reset values; no sample_valid; address = START_ADDR.
